sabr_prod_normalize: RTL and testbench
======================================

SABR_PROD_NORMALIZE -- requirements
Module: sabr_prod_normalize

Interface
REQ-001 SHALL have parameter PROD_WIDTH, default 87: width of the unsigned multiplier product.
REQ-002 SHALL have parameter OUT_WIDTH, default 64: width of the normalized result.
REQ-003 SHALL have parameter FRAC_SHIFT, default 23: number of fractional bits dropped; legal range 1..PROD_WIDTH-1.
REQ-004 SHALL have parameter MUL_LATENCY, default 4: number of ce-enabled edges from operand presentation to product at the multiplier dout.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1: upstream operands are present at the multiplier inputs this cycle.
REQ-008 SHALL have port in_ready, output, 1: equals mul_ce; an operand is accepted when in_valid && in_ready.
REQ-009 SHALL have port mul_ce, output, 1: clock enable driven to the multiplier.
REQ-010 SHALL have port prod, input, PROD_WIDTH: multiplier dout, unsigned.
REQ-011 SHALL have port out_valid, output, 1: out_data is valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts out_data this cycle.
REQ-013 SHALL have port out_data, output, OUT_WIDTH: rounded, saturated result.
REQ-014 SHALL have port out_sat, output, 1: out_data was saturated; qualified by out_valid.
REQ-015 SHALL have port sat_count, output, 16: number of saturated results delivered.

Function
REQ-016 SHALL combinationally drive mul_ce = !out_valid || out_ready.
REQ-017 SHALL keep a MUL_LATENCY-bit tag shift register that advances only on edges where mul_ce is high; tag[0] takes (in_valid && mul_ce), and tag[i] takes tag[i-1].
REQ-018 SHALL treat prod as valid when tag[MUL_LATENCY-1] is high; this aligns with the multiplier, which registers its inputs and then three product stages, all ce-gated.
REQ-019 SHALL, on an edge with mul_ce high and tag[MUL_LATENCY-1] high, load out_data and out_sat from the rounding function of prod and set out_valid.
REQ-020 SHALL, on an edge with mul_ce high and tag[MUL_LATENCY-1] low, clear out_valid when out_ready is high.
REQ-021 SHALL hold out_data, out_sat and out_valid stable while out_valid && !out_ready; the multiplier pipeline and tags freeze in that state, so no result is lost or duplicated.
REQ-022 SHALL compute rounding at PROD_WIDTH+1 bits: r = (prod + 2^(FRAC_SHIFT-1)) >> FRAC_SHIFT, which is round-half-up.
REQ-023 SHALL saturate: if r >= 2^OUT_WIDTH, then out_data = all ones and out_sat = 1; otherwise out_data = r[OUT_WIDTH-1:0] and out_sat = 0.
REQ-024 SHALL increment sat_count on each handshake (out_valid && out_ready && out_sat), sticking at 16'hFFFF.
REQ-025 SHALL give a fixed latency of MUL_LATENCY+1 edges from acceptance to out_valid when out_ready is held high.
REQ-026 SHALL sustain one accepted operand and one delivered result per cycle with out_ready held high.
REQ-027 SHALL, on a simultaneous output handshake and new product load, deliver the old result and present the new one the next cycle with out_valid remaining 1.

Reset
REQ-028 SHALL, on reset high at a clock edge, clear all tags, out_valid, out_data, out_sat and sat_count to 0, regardless of mul_ce.
REQ-029 SHALL drop, not deliver, any operands in flight when reset occurs; the multiplier's stale contents are ignored because the tags are zero.
REQ-030 SHALL drive mul_ce = 1 and in_ready = 1 in the first cycle after reset.

Structure
REQ-031 SHALL take PROD_WIDTH, OUT_WIDTH, FRAC_SHIFT and MUL_LATENCY defaults from shared package sabr_norm_pkg, alongside the fixed-point format constants used by the other SABR path stages.
REQ-032 SHALL place the rounding and saturation of REQ-022 and REQ-023 in one combinational sub-module, sabr_round_sat; the tag pipeline, handshake logic and counter stay in the top module.

Verification (FRAC_SHIFT=23, out_ready=1 unless stated)
REQ-033 SHALL cover exact value: prod = 3<<23 -> out_data=3, out_sat=0, out_valid exactly 5 edges after acceptance.
REQ-034 SHALL cover rounding boundary: prod = (5<<23)+(1<<22) -> 6; prod = (5<<23)+(1<<22)-1 -> 5.
REQ-035 SHALL cover saturation: prod = 2^87-1 -> out_data = 64'hFFFF_FFFF_FFFF_FFFF, out_sat=1, sat_count increments 0->1 on handshake; prod = 2^86 -> 2^63, out_sat=0.
REQ-036 SHALL cover backpressure: 8 back-to-back operands with out_ready low for 10 cycles mid-burst -> mul_ce low while out_valid is high, 8 results delivered in order, no duplicates.
REQ-037 SHALL cover reset mid-flight: reset with 3 operands in flight -> no out_valid in the following 6 cycles, sat_count=0, in_ready=1.
REQ-038 SHALL cover simultaneous events: a continuous stream with out_ready toggling every cycle -> every accepted operand delivered exactly once, out_data stable while stalled.

Source files
------------

// File: rtl/sabr_norm_pkg.sv
// Shared fixed-point format constants for the SABR evaluation path.
// Product normalization defaults live here alongside the operand formats.
package sabr_norm_pkg;

    localparam int SABR_OPND_WIDTH  = 44;
    localparam int SABR_COEF_WIDTH  = 43;
    localparam int SABR_FRAC_BITS   = 23;
    localparam int SABR_INT_BITS    = SABR_OPND_WIDTH - SABR_FRAC_BITS;

    localparam int SABR_PROD_WIDTH  = SABR_OPND_WIDTH + SABR_COEF_WIDTH;
    localparam int SABR_OUT_WIDTH   = 64;
    localparam int SABR_FRAC_SHIFT  = SABR_FRAC_BITS;
    localparam int SABR_MUL_LATENCY = 4;

    localparam int SABR_SAT_CNT_WIDTH = 16;

endpackage

// File: rtl/sabr_round_sat.sv
// Round-half-up and drop FRAC_SHIFT fraction bits, then saturate to
// OUT_WIDTH bits. Purely combinational.
module sabr_round_sat
    import sabr_norm_pkg::*;
#(
    parameter int PROD_WIDTH = SABR_PROD_WIDTH,
    parameter int OUT_WIDTH  = SABR_OUT_WIDTH,
    parameter int FRAC_SHIFT = SABR_FRAC_SHIFT
) (
    input  logic [PROD_WIDTH-1:0] prod,
    output logic [OUT_WIDTH-1:0]  data,
    output logic                  sat
);

    localparam logic [PROD_WIDTH:0] HALF =
        {{PROD_WIDTH{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);

    // One extra bit so the rounding increment can never wrap.
    logic [PROD_WIDTH:0] sum;
    logic [PROD_WIDTH:0] r;

    assign sum = {1'b0, prod} + HALF;
    assign r   = sum >> FRAC_SHIFT;

    if (PROD_WIDTH + 1 > OUT_WIDTH) begin : g_sat
        assign sat  = |r[PROD_WIDTH:OUT_WIDTH];
        assign data = sat ? {OUT_WIDTH{1'b1}} : r[OUT_WIDTH-1:0];
    end else begin : g_nosat
        assign sat  = 1'b0;
        assign data = OUT_WIDTH'(r);
    end

endmodule

// File: rtl/sabr_prod_normalize.sv
// Normalizes the ce-gated multiplier product into a rounded, saturated
// result with a valid/ready output and a saturation counter.
module sabr_prod_normalize
    import sabr_norm_pkg::*;
#(
    parameter int PROD_WIDTH  = SABR_PROD_WIDTH,
    parameter int OUT_WIDTH   = SABR_OUT_WIDTH,
    parameter int FRAC_SHIFT  = SABR_FRAC_SHIFT,
    parameter int MUL_LATENCY = SABR_MUL_LATENCY
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mul_ce,
    input  logic [PROD_WIDTH-1:0] prod,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_sat,
    output logic [15:0]           sat_count
);

    logic [MUL_LATENCY-1:0] tag;
    logic                   prod_valid;
    logic [OUT_WIDTH-1:0]   rs_data;
    logic                   rs_sat;
    logic                   sat_hs;

    // The whole multiplier freezes while a result waits downstream.
    assign mul_ce     = !out_valid || out_ready;
    assign in_ready   = mul_ce;
    assign prod_valid = tag[MUL_LATENCY-1];
    assign sat_hs     = out_valid && out_ready && out_sat;

    sabr_round_sat #(
        .PROD_WIDTH (PROD_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) u_round_sat (
        .prod (prod),
        .data (rs_data),
        .sat  (rs_sat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            tag <= '0;
        end else if (mul_ce) begin
            tag[0] <= in_valid;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                tag[i] <= tag[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (mul_ce) begin
            if (prod_valid) begin
                out_valid <= 1'b1;
                out_data  <= rs_data;
                out_sat   <= rs_sat;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sat_count <= '0;
        end else if (sat_hs && sat_count != 16'hFFFF) begin
            sat_count <= sat_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_sabr_prod_normalize.sv
// Directed bench with a ce-gated multiplier stub and an in-order
// scoreboard of expected results.
module tb_sabr_prod_normalize;

    localparam int PW = 87;
    localparam int OW = 64;

    typedef struct packed {
        logic [OW-1:0] data;
        logic          sat;
    } exp_t;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic [PW-1:0] op        = '0;
    logic [PW-1:0] prod;
    logic          in_ready;
    logic          mul_ce;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic          out_sat;
    logic [15:0]   sat_count;

    logic [PW-1:0] pipe [4];
    exp_t          sb [$];
    exp_t          mon_e;
    int            checks     = 0;
    int            errors     = 0;
    int            pushed     = 0;
    int            popped     = 0;
    int            stall_seen = 0;
    logic          stall_prev = 1'b0;
    logic [OW-1:0] held_data  = '0;
    logic          held_sat   = 1'b0;

    always #5 clk = ~clk;

    sabr_prod_normalize dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mul_ce    (mul_ce),
        .prod      (prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .sat_count (sat_count)
    );

    // Multiplier stub: operand passes through four ce-gated stages.
    initial for (int i = 0; i < 4; i++) pipe[i] = '0;

    always @(posedge clk) begin
        if (mul_ce) begin
            pipe[0] <= op;
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign prod = pipe[3];

    function automatic exp_t model(input logic [PW-1:0] p);
        logic [OW:0] q;
        exp_t        e;
        q      = {1'b0, p[PW-1:23]} + (OW+1)'(p[22]);
        e.sat  = q[OW];
        e.data = q[OW] ? {OW{1'b1}} : q[OW-1:0];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [OW-1:0] obs,
                       input logic [OW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor away from the active edge; inputs change at posedge+1.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && out_valid) begin
                chk("hold_data", out_data, held_data);
                chk("hold_sat", 64'(out_sat), 64'(held_sat));
            end
            if (out_valid && !out_ready) begin
                stall_seen++;
                chk("stall_ce", 64'(mul_ce), 64'(0));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", 64'(sb.size()), 64'(1));
                end else begin
                    mon_e = sb.pop_front();
                    chk("data", out_data, mon_e.data);
                    chk("sat", 64'(out_sat), 64'(mon_e.sat));
                    popped++;
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(op));
                pushed++;
            end
            stall_prev = out_valid && !out_ready;
            held_data  = out_data;
            held_sat   = out_sat;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [PW-1:0] v);
        int   n;
        logic ok;
        n        = 0;
        ok       = 1'b0;
        in_valid = 1'b1;
        op       = v;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready;
            tick();
            n++;
        end
        if (!ok) chk("send_timeout", 64'(ok), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            tick();
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'(0));
        chk("drain_idle", 64'(out_valid), 64'(0));
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset state
        tick();
        tick();
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_data", out_data, 64'(0));
        chk("rst_sat", 64'(out_sat), 64'(0));
        chk("rst_cnt", 64'(sat_count), 64'(0));
        reset = 1'b0;
        chk("rst_ce", 64'(mul_ce), 64'(1));
        chk("rst_ready", 64'(in_ready), 64'(1));

        // Exact value and latency
        in_valid = 1'b1;
        op       = 87'(3) << 23;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("latency", 64'(n), 64'(5));
        chk("exact_data", out_data, 64'(3));
        drain();

        // Rounding boundary
        send((87'(5) << 23) + (87'(1) << 22));
        send((87'(5) << 23) + (87'(1) << 22) - 87'(1));
        drain();

        // Saturation
        chk("sat_cnt0", 64'(sat_count), 64'(0));
        send({PW{1'b1}});
        drain();
        chk("sat_cnt1", 64'(sat_count), 64'(1));
        send(87'(1) << 86);
        drain();
        chk("sat_cnt_keep", 64'(sat_count), 64'(1));

        // Backpressure mid-burst
        stall_seen = 0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send((87'(i + 10) << 23) + 87'(i));
            end
            begin
                repeat (3) tick();
                out_ready = 1'b0;
                repeat (10) tick();
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_stalled", 64'(stall_seen > 0), 64'(1));
        chk("bp_count", 64'(popped), 64'(pushed));

        // Reset with operands in flight
        send(87'(100) << 23);
        send(87'(101) << 23);
        send(87'(102) << 23);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rst_fl_valid", 64'(out_valid), 64'(0));
        end
        chk("rst_fl_cnt", 64'(sat_count), 64'(0));
        chk("rst_fl_ready", 64'(in_ready), 64'(1));
        pushed = 0;
        popped = 0;

        // Continuous stream with out_ready toggling
        stall_seen = 0;
        fork
            begin
                for (int i = 0; i < 20; i++)
                    send((87'(i + 200) << 23) + (87'(i & 1) << 22));
            end
            begin
                repeat (60) begin
                    tick();
                    out_ready = ~out_ready;
                end
            end
        join
        drain();
        chk("tog_stalled", 64'(stall_seen > 0), 64'(1));
        chk("tog_pushed", 64'(pushed), 64'(20));
        chk("tog_count", 64'(popped), 64'(pushed));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
